// File: rtl/lane_vinsn_queue_pkg.sv
// ==========================================================================
// lane_vinsn_queue_pkg : shared lane request/response types and FSM states
// Revision 1.0
// ==========================================================================
`default_nettype none

package lane_vinsn_queue_pkg;

  localparam int unsigned NrVInsn          = 8;
  localparam int unsigned VLenWidth        = 16;
  localparam int unsigned LaneElemCntWidth = 8;

  typedef logic [VLenWidth-1:0]       vlen_t;
  typedef logic [$clog2(NrVInsn)-1:0] vid_t;

  typedef enum logic [2:0] {
    VFU_None,
    VFU_Alu,
    VFU_MFpu,
    VFU_LoadUnit,
    VFU_StoreUnit,
    VFU_SlideUnit,
    VFU_MaskUnit
  } vfu_e;

  typedef struct packed {
    vid_t               id;
    vfu_e               vfu;
    logic [7:0]         op;
    vlen_t              vl;
    vlen_t              vstart;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vd;
    logic [NrVInsn-1:0] hazard_vm;
    logic [NrVInsn-1:0] vinsn_running;
  } pe_req_t;

  typedef struct packed {
    logic [NrVInsn-1:0] vinsn_done;
  } pe_resp_t;

  typedef logic [2:0] lane_fsm_e;
  localparam lane_fsm_e IDLE     = 3'd0;
  localparam lane_fsm_e WAIT_HAZ = 3'd1;
  localparam lane_fsm_e ISSUE    = 3'd2;
  localparam lane_fsm_e EXEC     = 3'd3;
  localparam lane_fsm_e DONE     = 3'd4;

  function automatic logic is_lane_vfu(input vfu_e vfu);
    return (vfu == VFU_Alu) || (vfu == VFU_MFpu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_vinsn_queue_fifo.sv
// ==========================================================================
// fifo_v3 : generic synchronous FIFO, first-word-fall-through read port
// Revision 1.0
// ==========================================================================
`default_nettype none

module fifo_v3 #(
  parameter int unsigned DEPTH = 4,
  parameter type         DTYPE = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  DTYPE i_data,
  output DTYPE o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  DTYPE             r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/lane_vinsn_queue.sv
// ==========================================================================
// lane_vinsn_queue : per-lane in-order instruction queue, hazard gate, done pulse
// Rev 1.0 -- optional stall counter under LANE_VINSN_QUEUE_STALL_CNT_EN
// ==========================================================================
`default_nettype none

module lane_vinsn_queue
  import lane_vinsn_queue_pkg::*;
#(
  parameter int unsigned NrLanes    = 1,
  parameter int unsigned QueueDepth = 4,
  localparam int unsigned LaneIdW   = (NrLanes > 1) ? $clog2(NrLanes) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [LaneIdW-1:0]          lane_id_i,
  input  pe_req_t                     pe_req_i,
  input  logic                        pe_req_valid_i,
  output logic                        pe_req_ready_o,
  output pe_resp_t                    pe_resp_o,
  output logic                        issue_valid_o,
  input  logic                        issue_ready_i,
  output pe_req_t                     issue_req_o,
  input  logic                        elem_valid_i,
  input  logic [LaneElemCntWidth-1:0] elem_cnt_i,
  output logic [31:0]                 stall_cnt_o
);

  pe_req_t            w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  lane_fsm_e          r_state;
  lane_fsm_e          w_state_nxt;
  vlen_t              r_elem_ctr;
  pe_resp_t           r_resp;
  logic [VLenWidth:0] w_vl_sum;
  vlen_t              w_lane_vl;
  logic [VLenWidth:0] w_elem_sum;
  logic               w_last;
  logic [NrVInsn-1:0] w_live;
  logic               w_blocked;
  logic [NrVInsn-1:0] w_done_onehot;

  // Non-lane VFUs are still acknowledged; they simply never enter the queue.
  assign pe_req_ready_o = ~w_full;
  assign w_push         = pe_req_valid_i & ~w_full & is_lane_vfu(pe_req_i.vfu);
  assign w_pop          = (r_state == DONE);

  fifo_v3 #(
    .DEPTH (QueueDepth),
    .DTYPE (pe_req_t)
  ) u_queue (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (pe_req_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Lanes with a lower index take the remainder elements.
  assign w_vl_sum  = {1'b0, w_head.vl} + (VLenWidth+1)'(NrLanes - 1) - (VLenWidth+1)'(lane_id_i);
  assign w_lane_vl = vlen_t'(w_vl_sum / (VLenWidth+1)'(NrLanes));

  assign w_elem_sum = {1'b0, r_elem_ctr} + (VLenWidth+1)'(elem_cnt_i);
  assign w_last     = elem_valid_i && (w_elem_sum >= {1'b0, w_lane_vl});

  // The done term hides the running vector's one-cycle lag behind our own pulse.
  assign w_live    = pe_req_i.vinsn_running & ~pe_resp_o.vinsn_done;
  assign w_blocked = |((w_head.hazard_vs1 | w_head.hazard_vs2 |
                        w_head.hazard_vd  | w_head.hazard_vm) & w_live);

  assign w_done_onehot = {{(NrVInsn-1){1'b0}}, 1'b1} << w_head.id;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (!w_empty)      w_state_nxt = WAIT_HAZ;
      WAIT_HAZ: if (!w_blocked)    w_state_nxt = (w_lane_vl == '0) ? DONE : ISSUE;
      ISSUE:    if (issue_ready_i) w_state_nxt = EXEC;
      EXEC:     if (w_last)        w_state_nxt = DONE;
      DONE:                        w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_elem_ctr <= '0;
      r_resp     <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_resp.vinsn_done <= (w_state_nxt == DONE) ? w_done_onehot : '0;
      if (r_state == DONE)
        r_elem_ctr <= '0;
      else if (r_state == EXEC && elem_valid_i)
        r_elem_ctr <= vlen_t'(w_elem_sum);
    end
  end

  assign pe_resp_o     = r_resp;
  assign issue_valid_o = (r_state == ISSUE);
  assign issue_req_o   = w_head;

`ifdef LANE_VINSN_QUEUE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_stall_cnt <= '0;
    else if (r_state == WAIT_HAZ && w_blocked && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lane_vinsn_queue.sv
// Bench for lane_vinsn_queue (NrLanes=4, QueueDepth=4): directed scenarios plus
// randomized traffic, all checked against a transaction-level queue model.
`default_nettype none

module tb_lane_vinsn_queue;
  import lane_vinsn_queue_pkg::*;

  localparam int NL = 4;
  localparam int QD = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  lane_id;
  pe_req_t     req;
  logic        req_valid;
  logic        req_ready;
  pe_resp_t    resp;
  logic        issue_valid;
  logic        issue_ready;
  pe_req_t     issue_req;
  logic        elem_valid;
  logic [7:0]  elem_cnt;
  logic [31:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  lane_vinsn_queue #(.NrLanes(NL), .QueueDepth(QD)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .lane_id_i      (lane_id),
    .pe_req_i       (req),
    .pe_req_valid_i (req_valid),
    .pe_req_ready_o (req_ready),
    .pe_resp_o      (resp),
    .issue_valid_o  (issue_valid),
    .issue_ready_i  (issue_ready),
    .issue_req_o    (issue_req),
    .elem_valid_i   (elem_valid),
    .elem_cnt_i     (elem_cnt),
    .stall_cnt_o    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: life of the queue head ----------------
  pe_req_t     mq[$];
  bit          m_on, m_armed, m_offer, m_exec, m_done;
  int          m_elems;
  logic [31:0] m_stall;

  function automatic logic [7:0] m_done_mask();
    return m_done ? (8'd1 << mq[0].id) : 8'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_on = 1; m_armed = 0; m_offer = 0; m_exec = 0; m_done = 0;
      m_elems = 0; m_stall = '0;
    end else if (m_on) begin : step
      bit take;
      bit blk;
      int lvl;
      take = (mq.size() < QD);
      blk  = 0;
      lvl  = 0;
      if (mq.size() > 0) begin
        blk = |((mq[0].hazard_vs1 | mq[0].hazard_vs2 | mq[0].hazard_vd | mq[0].hazard_vm)
                & req.vinsn_running & ~m_done_mask());
        lvl = (int'(mq[0].vl) + NL - 1 - int'(lane_id)) / NL;
      end
      if (m_armed && blk && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (m_done) begin
        mq.delete(0);
        m_done = 0;
      end else if (m_exec) begin
        if (elem_valid) begin
          if (m_elems + int'(elem_cnt) >= lvl) begin
            m_exec = 0; m_done = 1; m_elems = 0;
          end else m_elems += int'(elem_cnt);
        end
      end else if (m_offer) begin
        if (issue_ready) begin m_offer = 0; m_exec = 1; end
      end else if (m_armed) begin
        if (!blk) begin
          m_armed = 0;
          if (lvl == 0) m_done = 1; else m_offer = 1;
        end
      end else if (mq.size() > 0) m_armed = 1;
      if (req_valid && take && (req.vfu == VFU_Alu || req.vfu == VFU_MFpu)) mq.push_back(req);
    end
  end

  always @(negedge clk) begin
    if (m_on && !rst) begin
      chk("ready", 128'(req_ready), 128'(mq.size() < QD));
      chk("issue_valid", 128'(issue_valid), 128'(m_offer));
      chk("vinsn_done", 128'(resp.vinsn_done), 128'(m_done_mask()));
      if (m_offer) chk("issue_req", 128'(issue_req), 128'(mq[0]));
`ifdef LANE_VINSN_QUEUE_STALL_CNT_EN
      chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
`else
      chk("stall_cnt", 128'(stall_cnt), 128'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pe_req_t mk(input int id, input vfu_e vfu, input int vl);
    pe_req_t r;
    r = '0;
    r.id  = vid_t'(id);
    r.vfu = vfu;
    r.op  = 8'h01;
    r.vl  = vlen_t'(vl);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1; req_valid = 0; issue_ready = 0; elem_valid = 0; elem_cnt = 8'd1;
    req = '0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic drive_random();
    req_valid   = ($urandom % 3) == 0;
    req         = '0;
    req.id      = vid_t'($urandom % 8);
    req.vfu     = vfu_e'($urandom_range(0, 6));
    req.op      = 8'($urandom);
    req.vl      = (($urandom % 3) == 0) ? vlen_t'($urandom_range(0, 3)) : vlen_t'($urandom_range(0, 40));
    req.hazard_vs1 = 8'($urandom) & 8'($urandom) & 8'($urandom);
    req.hazard_vs2 = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
    req.hazard_vd  = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
    req.hazard_vm  = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
    req.vinsn_running = 8'($urandom) & 8'($urandom) & 8'($urandom);
    issue_ready = ($urandom % 2) == 0;
    elem_valid  = ($urandom % 2) == 0;
    elem_cnt    = (($urandom % 8) == 0) ? 8'd255 : 8'($urandom_range(1, 4));
  endtask

  initial begin
    m_on = 0;
    rst = 1; lane_id = 2'd1; req = '0; req_valid = 0;
    issue_ready = 0; elem_valid = 0; elem_cnt = 8'd1;
    do_reset();
    chk("reset_ready", 128'(req_ready), 128'd1);
    chk("reset_valid", 128'(issue_valid), 128'd0);
    chk("reset_done", 128'(resp.vinsn_done), 128'd0);
    chk("reset_stall", 128'(stall_cnt), 128'd0);

    // lane 1, vl=10 -> 3 elements on this lane
    req = mk(5, VFU_Alu, 10); req_valid = 1;
    tick(); req_valid = 0;
    chk("s1_iv_e0", 128'(issue_valid), 128'd0);
    tick(); chk("s1_iv_e1", 128'(issue_valid), 128'd0);
    tick(); chk("s1_iv_e2", 128'(issue_valid), 128'd1);
    chk("s1_req_id", 128'(issue_req.id), 128'd5);
    issue_ready = 1; tick(); issue_ready = 0;
    chk("s1_iv_exec", 128'(issue_valid), 128'd0);
    elem_valid = 1; elem_cnt = 8'd1;
    tick(); chk("s1_done_1", 128'(resp.vinsn_done), 128'd0);
    tick(); chk("s1_done_2", 128'(resp.vinsn_done), 128'd0);
    tick(); chk("s1_done_3", 128'(resp.vinsn_done), 128'h20);
    chk("s1_model_pin", 128'(m_done), 128'd1);
    tick(); chk("s1_done_4", 128'(resp.vinsn_done), 128'd0);
    elem_valid = 0; tick();

    // hazard on vinsn 2 held for five stall cycles
    do_reset();
    lane_id = 2'd1;
    req = mk(3, VFU_MFpu, 4); req.hazard_vs1 = 8'h04; req.vinsn_running = 8'h04;
    req_valid = 1; tick(); req_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick(); chk("s2_blocked", 128'(issue_valid), 128'd0);
    end
    req.vinsn_running = 8'h00;
    tick(); chk("s2_issue", 128'(issue_valid), 128'd1);
`ifdef LANE_VINSN_QUEUE_STALL_CNT_EN
    chk("s2_stall", 128'(stall_cnt), 128'd5);
`else
    chk("s2_stall", 128'(stall_cnt), 128'd0);
`endif
    issue_ready = 1; tick(); issue_ready = 0;
    elem_valid = 1; elem_cnt = 8'd1; tick(); elem_valid = 0;
    chk("s2_done", 128'(resp.vinsn_done), 128'h08);
    tick();

    // fill the queue, then hold a fifth broadcast until the first pop
    do_reset();
    lane_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      req = mk(i, VFU_Alu, 1); req_valid = 1; tick();
    end
    req = mk(4, VFU_Alu, 1);
    chk("s3_full", 128'(req_ready), 128'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("s3_hold", 128'(req_ready), 128'd0);
    end
    issue_ready = 1; tick(); issue_ready = 0;
    elem_valid = 1; elem_cnt = 8'd1; tick(); elem_valid = 0;
    chk("s3_pop_ready", 128'(req_ready), 128'd0);
    chk("s3_pop_done", 128'(resp.vinsn_done), 128'h01);
    tick(); chk("s3_after_pop", 128'(req_ready), 128'd1);
    tick(); req_valid = 0;
    chk("s3_refull", 128'(req_ready), 128'd0);
    issue_ready = 1; elem_valid = 1; elem_cnt = 8'd255;
    repeat (40) tick();
    issue_ready = 0; elem_valid = 0;

    // non-lane VFU: acknowledged and dropped
    req = mk(6, VFU_LoadUnit, 8); req_valid = 1;
    chk("s4_ready", 128'(req_ready), 128'd1);
    tick(); req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s4_no_issue", 128'(issue_valid), 128'd0);
      chk("s4_no_done", 128'(resp.vinsn_done), 128'd0);
    end

    // lane 3, vl=3 -> no elements here, straight to done
    do_reset();
    lane_id = 2'd3;
    req = mk(2, VFU_Alu, 3); req_valid = 1; tick(); req_valid = 0;
    tick(); chk("s5_done_e1", 128'(resp.vinsn_done), 128'd0);
    tick(); chk("s5_done_e2", 128'(resp.vinsn_done), 128'h04);
    chk("s5_no_issue", 128'(issue_valid), 128'd0);
    tick(); chk("s5_done_e3", 128'(resp.vinsn_done), 128'd0);

    // reset in the middle of execution with two queued
    do_reset();
    lane_id = 2'd0;
    req = mk(0, VFU_Alu, 8); req_valid = 1; tick();
    req = mk(1, VFU_Alu, 8); tick(); req_valid = 0;
    tick();
    issue_ready = 1; tick(); issue_ready = 0;
    elem_valid = 1; elem_cnt = 8'd2; tick();
    rst = 1; elem_valid = 0; tick();
    chk("s6_ready", 128'(req_ready), 128'd1);
    chk("s6_valid", 128'(issue_valid), 128'd0);
    chk("s6_done", 128'(resp.vinsn_done), 128'd0);
    chk("s6_stall", 128'(stall_cnt), 128'd0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s6_idle_valid", 128'(issue_valid), 128'd0);
      chk("s6_idle_done", 128'(resp.vinsn_done), 128'd0);
    end

    // randomized traffic on every lane index
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      lane_id = 2'(seg);
      for (int c = 0; c < 1500; c++) begin
        drive_random();
        tick();
      end
    end

    req_valid = 0; elem_valid = 0; issue_ready = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
